// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
// Adds two 4*NIBBLES-bit operands one nibble at a time through an external,
// registered 4-bit adder stage of latency LAT. Each nibble's carry-out is fed
// back as the next nibble's carry-in. A start/done handshake hides the
// adder's latency from the requester.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4,
    parameter int LAT     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 cin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_ci,
    input  logic [3:0]           add_s,
    input  logic                 add_co
);

    localparam int W        = 4 * NIBBLES;
    localparam int IW       = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int WCW      = (LAT > 2) ? $clog2(LAT - 1) : 1;
    localparam bit HAS_WAIT = (LAT > 1);

    localparam logic [IW-1:0]  IDX_LAST  = IW'(NIBBLES - 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((LAT > 1) ? LAT - 2 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t          state_q,   state_d;
    logic [W-1:0]    op_a_q,    op_a_d;
    logic [W-1:0]    op_b_q,    op_b_d;
    logic [IW-1:0]   idx_q,     idx_d;
    logic [WCW-1:0]  wait_q,    wait_d;
    logic [W-1:0]    partial_q, partial_d;
    logic [W-1:0]    result_q,  result_d;
    logic            cout_q,    cout_d;
    logic [3:0]      add_a_q,   add_a_d;
    logic [3:0]      add_b_q,   add_b_d;
    logic            add_ci_q,  add_ci_d;

    // Next-state and datapath updates for the nibble sequencer.
    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a
        // signal unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        idx_d     = idx_q;
        wait_d    = wait_q;
        partial_d = partial_q;
        result_d  = result_q;
        cout_d    = cout_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_ci_d  = add_ci_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_a_d   = op_a;
                    op_b_d   = op_b;
                    add_a_d  = op_a[3:0];
                    add_b_d  = op_b[3:0];
                    add_ci_d = cin;
                    idx_d    = '0;
                    state_d  = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // The adder samples add_* at the end of this cycle.
                if (HAS_WAIT) begin
                    wait_d  = '0;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_CAPTURE;
                end
            end

            S_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = S_CAPTURE;
                end else begin
                    wait_d = wait_q + WCW'(1);
                end
            end

            S_CAPTURE: begin
                // add_s/add_co are only trusted here; the adder has no reset.
                partial_d[4*int'(idx_q) +: 4] = add_s;
                if (idx_q != IDX_LAST) begin
                    idx_d    = idx_q + IW'(1);
                    add_a_d  = op_a_q[4*int'(idx_d) +: 4];
                    add_b_d  = op_b_q[4*int'(idx_d) +: 4];
                    add_ci_d = add_co;
                    state_d  = S_ISSUE;
                end else begin
                    result_d = partial_d;
                    cout_d   = add_co;
                    state_d  = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge
        // value of every other flop, independent of statement order.
        if (rst) begin
            state_q   <= S_IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            idx_q     <= '0;
            wait_q    <= '0;
            partial_q <= '0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            add_a_q   <= '0;
            add_b_q   <= '0;
            add_ci_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            idx_q     <= idx_d;
            wait_q    <= wait_d;
            partial_q <= partial_d;
            result_q  <= result_d;
            cout_q    <= cout_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            add_ci_q  <= add_ci_d;
        end
    end

    assign busy   = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_CAPTURE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign add_a  = add_a_q;
    assign add_b  = add_b_q;
    assign add_ci = add_ci_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: a registered 4-bit adder model with
// unreset, randomly seeded pipeline registers sits on the adder port; results
// are compared against plain 16-bit arithmetic on the operands.
module tb_nibble_serial_add_ctrl;

    localparam int NIB    = 4;
    localparam int LAT    = 2;
    localparam int W      = 4 * NIB;
    localparam int PER    = LAT + 1;
    localparam int DONE_C = 1 + NIB * PER;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_ci;
    logic [3:0]   add_s;
    logic         add_co;

    int n_total = 0;
    int n_bad   = 0;

    logic [W-1:0] hold_res;
    logic         hold_cout;

    nibble_serial_add_ctrl #(.NIBBLES(NIB), .LAT(LAT)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .add_a  (add_a),
        .add_b  (add_b),
        .add_ci (add_ci),
        .add_s  (add_s),
        .add_co (add_co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External adder stage: two register stages, no reset, garbage at start.
    logic [4:0] pipe1, pipe2;
    initial begin
        pipe1 = 5'($urandom);
        pipe2 = 5'($urandom);
    end
    always @(posedge clk) begin
        pipe1 <= {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_ci};
        pipe2 <= pipe1;
    end
    assign add_s  = pipe2[3:0];
    assign add_co = pipe2[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Carry into nibble k: carry out of the sum of the lower k nibbles plus cin.
    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic ci, input int k);
        logic [W:0] m;
        logic [W:0] s;
        m = (({{W{1'b0}}, 1'b1}) << (4 * k)) - 1'b1;
        s = ({1'b0, a} & m) + ({1'b0, b} & m) + {{W{1'b0}}, ci};
        return s[4*k];
    endfunction

    // One full operation starting in the current (IDLE) cycle.
    // mode 0: start pulse; 1: start held, op_a changed at cycle 5;
    // 2: random start/operand noise while busy.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input int mode);
        logic [W:0] full;
        int k;
        full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        cin   = ci;
        @(negedge clk);
        check("c0_busy", busy, 0);
        check("c0_done", done, 0);
        for (int c = 1; c <= DONE_C; c++) begin
            @(posedge clk);
            #1;
            case (mode)
                0: start = 1'b0;
                1: if (c == 5) op_a = 16'h00FF;
                default: begin
                    start = 1'($urandom);
                    op_a  = 16'($urandom);
                    op_b  = 16'($urandom);
                    cin   = 1'($urandom);
                end
            endcase
            @(negedge clk);
            check("busy", busy, (c < DONE_C));
            check("done", done, (c == DONE_C));
            if (c < DONE_C) begin
                check("result_hold", result, hold_res);
                check("cout_hold", cout, hold_cout);
            end else begin
                check("result", result, full[W-1:0]);
                check("cout", cout, full[W]);
            end
            if (((c - 1) % PER) == 0 && c < DONE_C) begin
                k = (c - 1) / PER;
                check("issue_add_a", add_a, a[4*k +: 4]);
                check("issue_add_b", add_b, b[4*k +: 4]);
                check("issue_add_ci", add_ci, carry_into(a, b, ci, k));
            end
        end
        hold_res  = full[W-1:0];
        hold_cout = full[W];
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        hold_res  = '0;
        hold_cout = 1'b0;
        rst   = 1'b1;
        start = 1'b1;
        op_a  = 16'hFFFF;
        op_b  = 16'hFFFF;
        cin   = 1'b1;

        // Reset with start held high.
        repeat (3) begin
            @(negedge clk);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_result", result, 0);
            check("rst_cout", cout, 0);
            check("rst_add_a", add_a, 0);
            check("rst_add_b", add_b, 0);
            check("rst_add_ci", add_ci, 0);
        end
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("post_rst_busy", busy, 0);
        end
        @(posedge clk);
        #1;

        // Directed cases.
        run_op(16'h1234, 16'h4321, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 0);
        run_op(16'h0000, 16'h0000, 1'b0, 0);

        // Start held high; second operation starts back-to-back at cycle 14.
        run_op(16'h3C5A, 16'h1111, 1'b0, 1);
        run_op(16'h00FF, 16'h1111, 1'b0, 0);

        // Mid-operation reset.
        start = 1'b1;
        op_a  = 16'h8888;
        op_b  = 16'h8888;
        cin   = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) start = 1'b0;
            if (c == 6) rst = 1'b1;
            if (c == 7) rst = 1'b0;
        end
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_cout", cout, 0);
        check("abort_add_a", add_a, 0);
        check("abort_add_b", add_b, 0);
        check("abort_add_ci", add_ci, 0);
        hold_res  = '0;
        hold_cout = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        @(posedge clk);
        #1;
        run_op(16'h0F0F, 16'h00F1, 1'b0, 0);

        // Randomized operations with idle gaps and start/operand noise.
        for (int i = 0; i < 16; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), (i % 2 == 1) ? 2 : 0);
            start = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
